// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the TX/RX state encodings.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock input FIFO for uart_tx; instantiated only when UART_TX_FIFO_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready input; define UART_TX_FIFO_EN to add an
// input FIFO of FIFO_DEPTH entries in front of the serialiser.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      i_clk_uart,
  input  logic                      i_rst_n,
  input  logic [UART_DATA_BITS-1:0] i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 1 || (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx: illegal parameter value");
  end

  uart_tx_state_t            r_state;
  uart_tx_state_t            w_next;
  logic [BAUD_W-1:0]         r_baud;
  logic [2:0]                r_bit;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_tx;
  logic                      r_stop_end_q;
  logic                      r_done;
  logic                      w_tick;
  logic                      w_stop_end;
  logic                      w_fsm_ready;
  logic                      w_load;
  logic                      w_cur_bit;
  logic                      w_tx_next;
  logic [UART_DATA_BITS-1:0] w_load_data;

  assign w_tick      = (r_baud == BAUD_LAST);
  assign w_stop_end  = (r_state == STOP) && w_tick && (r_bit == STOP_LAST);
  assign w_fsm_ready = (r_state == IDLE) || w_stop_end;
  assign w_cur_bit   = (MSB_FIRST != 0) ? r_shift[UART_DATA_BITS-1] : r_shift[0];

`ifdef UART_TX_FIFO_EN
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [UART_DATA_BITS-1:0] w_fifo_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .i_clk   (i_clk_uart),
    .i_rst_n (i_rst_n),
    .i_push  (i_valid),
    .i_data  (i_data),
    .i_pop   (w_load),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_load      = w_fsm_ready && !w_fifo_empty;
  assign w_load_data = w_fifo_data;
  assign o_ready     = !w_fifo_full;
  assign o_busy      = (r_state != IDLE) || !w_fifo_empty;
`else
  // Ready in the last stop cycle lets the next frame start with no idle gap.
  assign w_load      = w_fsm_ready && i_valid;
  assign w_load_data = i_data;
  assign o_ready     = w_fsm_ready;
  assign o_busy      = (r_state != IDLE);
`endif

  always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_load) w_next = START;
      START:   if (w_tick) w_next = DATA;
      DATA:    if (w_tick && (r_bit == BIT_LAST)) w_next = STOP;
      STOP:    if (w_stop_end) w_next = w_load ? START : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_tx_next = UART_LINE_IDLE;
    case (r_state)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_cur_bit;
      default: w_tx_next = UART_LINE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      if (r_state == IDLE || w_tick) r_baud <= '0;
      else                           r_baud <= r_baud + 1'b1;

      if (r_state != w_next)                              r_bit <= '0;
      else if (w_tick && (r_state == DATA || r_state == STOP)) r_bit <= r_bit + 1'b1;

      if (w_load) r_shift <= w_load_data;
      else if (r_state == DATA && w_tick)
        r_shift <= (MSB_FIRST != 0) ? {r_shift[UART_DATA_BITS-2:0], 1'b0}
                                    : {1'b0, r_shift[UART_DATA_BITS-1:1]};
    end
  end

  // The line and done flag lag the state by one edge, so done trails the stop bit.
  always_ff @(posedge i_clk_uart or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx         <= UART_LINE_IDLE;
      r_stop_end_q <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_tx         <= w_tx_next;
      r_stop_end_q <= w_stop_end;
      r_done       <= r_stop_end_q;
    end
  end

  assign o_tx   = r_tx;
  assign o_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: one default instance and one with
// CLKS_PER_BIT=4, STOP_BITS=2, MSB_FIRST=0; FIFO scenario when UART_TX_FIFO_EN is defined.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       tx_a, ready_a, busy_a, done_a;
  logic       tx_b, ready_b, busy_b, done_b;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  uart_tx dut_a (
    .i_clk_uart (clk),
    .i_rst_n    (rst_n),
    .i_data     (data_a),
    .i_valid    (valid_a),
    .o_ready    (ready_a),
    .o_tx       (tx_a),
    .o_busy     (busy_a),
    .o_done     (done_a)
  );

  uart_tx #(
    .CLKS_PER_BIT (4),
    .STOP_BITS    (2),
    .MSB_FIRST    (0)
  ) dut_b (
    .i_clk_uart (clk),
    .i_rst_n    (rst_n),
    .i_data     (data_b),
    .i_valid    (valid_b),
    .o_ready    (ready_b),
    .o_tx       (tx_b),
    .o_busy     (busy_b),
    .o_done     (done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input bit sel, output logic tx, output logic rdy,
                        output logic bsy, output logic dn);
    tx  = sel ? tx_b    : tx_a;
    rdy = sel ? ready_b : ready_a;
    bsy = sel ? busy_b  : busy_a;
    dn  = sel ? done_b  : done_a;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      valid_b = v;
      data_b  = d;
    end else begin
      valid_a = v;
      data_a  = d;
    end
  endtask

`ifndef UART_TX_FIFO_EN
  // Sends one byte and checks every bit period, ready, busy and done against a
  // frame model; mid-bit samples are reassembled as a receiver would.
  task automatic run_frame(input bit sel, input logic [7:0] b, input int cpb,
                           input int nstop, input bit msbf);
    int         total;
    int         slot;
    int         ph;
    logic [7:0] rx;
    logic       tx, rdy, bsy, dn, exp_tx;
    total = (9 + nstop) * cpb;
    rx    = 8'h00;
    @(negedge clk);
    sample(sel, tx, rdy, bsy, dn);
    check("pre_ready", 32'(rdy), 32'(1));
    drive(sel, 1'b1, b);
    @(negedge clk);
    drive(sel, 1'b0, ~b);
    sample(sel, tx, rdy, bsy, dn);
    check("acc_tx", 32'(tx), 32'(1));
    check("acc_busy", 32'(bsy), 32'(1));
    check("acc_ready", 32'(rdy), 32'(0));
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      sample(sel, tx, rdy, bsy, dn);
      slot = (k - 1) / cpb;
      ph   = (k - 1) % cpb;
      if (k > total)      exp_tx = 1'b1;
      else if (slot == 0) exp_tx = 1'b0;
      else if (slot <= 8) exp_tx = msbf ? b[8 - slot] : b[slot - 1];
      else                exp_tx = 1'b1;
      check($sformatf("tx[%0d]", k), 32'(tx), 32'(exp_tx));
      check($sformatf("ready[%0d]", k), 32'(rdy), 32'(k >= total - 1));
      check($sformatf("busy[%0d]", k), 32'(bsy), 32'(k < total));
      check($sformatf("done[%0d]", k), 32'(dn), 32'(k == total + 1));
      if (slot >= 1 && slot <= 8 && ph == cpb / 2)
        rx = msbf ? {rx[6:0], tx} : {tx, rx[7:1]};
    end
    check("rx_byte", 32'(rx), 32'(b));
    @(negedge clk);
    sample(sel, tx, rdy, bsy, dn);
    check("post_done", 32'(dn), 32'(0));
    check("post_busy", 32'(bsy), 32'(0));
  endtask

  logic line_s [23];
  logic done_s [23];
`endif

  initial begin
    rst_n   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = 8'h00;
    data_b  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_a", 32'({tx_a, ready_a, busy_a, done_a}), 32'(4'b1100));
    check("rst_b", 32'({tx_b, ready_b, busy_b, done_b}), 32'(4'b1100));
    rst_n = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("idle[%0d]", i), 32'({tx_a, ready_a, busy_a, done_a}), 32'(4'b1100));
    end

`ifndef UART_TX_FIFO_EN
    begin : t_basic
      run_frame(1'b0, 8'hA5, 1, 1, 1'b1);
    end

    begin : t_back_to_back
      int acc_k;
      acc_k = -1;
      @(negedge clk);
      check("b2b_pre_ready", 32'(ready_a), 32'(1));
      valid_a = 1'b1;
      data_a  = 8'h00;
      for (int k = 0; k < 23; k++) begin
        @(negedge clk);
        line_s[k] = tx_a;
        done_s[k] = done_a;
        if (k == 0)          data_a  = 8'hFF;
        else if (acc_k >= 0) valid_a = 1'b0;
        else if (ready_a)    acc_k   = k;
      end
      valid_a = 1'b0;
      check("b2b_accept_cycle", 32'(acc_k), 32'(9));
      for (int k = 1; k < 23; k++) begin
        check($sformatf("b2b_tx[%0d]", k), 32'(line_s[k]),
              32'(!(k == 1 || k == 11 || (k >= 2 && k <= 9))));
        check($sformatf("b2b_done[%0d]", k), 32'(done_s[k]), 32'(k == 11 || k == 21));
      end
    end

    begin : t_slow
      run_frame(1'b1, 8'h3C, 4, 2, 1'b0);
      run_frame(1'b1, 8'h01, 4, 2, 1'b0);
    end

    begin : t_reset_mid_frame
      @(negedge clk);
      valid_a = 1'b1;
      data_a  = 8'h81;
      @(negedge clk);
      valid_a = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_mid_pre_tx", 32'(tx_a), 32'(0));
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx", 32'(tx_a), 32'(1));
      check("rst_mid_busy", 32'(busy_a), 32'(0));
      check("rst_mid_ready", 32'(ready_a), 32'(1));
      check("rst_mid_done", 32'(done_a), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(1'b0, 8'h42, 1, 1, 1'b1);
    end
`else
    begin : t_fifo
      logic [7:0] bytes [5];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      fork
        begin : drv
          int   idx;
          int   guard;
          logic rdy;
          idx   = 0;
          guard = 0;
          @(negedge clk);
          while (idx < 5 && guard < 100) begin
            data_a  = bytes[idx];
            valid_a = 1'b1;
            rdy     = ready_a;
            @(negedge clk);
            if (rdy) idx++;
            guard++;
          end
          valid_a = 1'b0;
          check("fifo_pushed", 32'(idx), 32'(5));
          check("fifo_full_ready", 32'(ready_a), 32'(0));
          check("fifo_busy", 32'(busy_a), 32'(1));
        end
        begin : mon
          logic [7:0] b;
          int         wait_n;
          for (int f = 0; f < 5; f++) begin
            wait_n = 0;
            do begin
              @(negedge clk);
              wait_n++;
            end while (tx_a !== 1'b0 && wait_n < 200);
            if (tx_a !== 1'b0) begin
              check("fifo_mon_timeout", 32'(0), 32'(1));
              break;
            end
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
              @(negedge clk);
              b = {b[6:0], tx_a};
            end
            @(negedge clk);
            check($sformatf("fifo_stop[%0d]", f), 32'(tx_a), 32'(1));
            check($sformatf("fifo_byte[%0d]", f), 32'(b), 32'(bytes[f]));
          end
        end
      join
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        check($sformatf("fifo_tail_tx[%0d]", i), 32'(tx_a), 32'(1));
      end
      check("fifo_end_busy", 32'(busy_a), 32'(0));
      check("fifo_end_ready", 32'(ready_a), 32'(1));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 serial transmitter; the transmit counterpart of the board's UART receiver, driving the host-facing TX line.
- Shares the receiver's bit-rate clock `i_clk_uart`; default is one bit period per clock cycle.
- Accepts bytes through a valid/ready handshake, serialises them, and pulses a done flag after each frame.

Parameters:
- `CLKS_PER_BIT`, 1: `i_clk_uart` cycles per bit period; must be ≥1.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.
- `MSB_FIRST`, 1: 1 = data bit 7 is sent first; 0 = bit 0 is sent first. Default 1 matches the receiver, which shifts the first data bit into bit 7.
- `FIFO_DEPTH`, 4: entries in the input FIFO; power of two, ≥2; used only with `UART_TX_FIFO_EN`.

Ports:
- `i_clk_uart`, in, 1: bit-rate clock; the block's only clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_data`, in, 8: byte to transmit.
- `i_valid`, in, 1: `i_data` is valid.
- `o_ready`, out, 1: block can accept a byte; a transfer occurs on any edge where `i_valid` && `o_ready`.
- `o_tx`, out, 1: serial line; idles high; registered output.
- `o_busy`, out, 1: a frame is in progress (any state except IDLE).
- `o_done`, out, 1: one-cycle pulse in the cycle after the last stop-bit period ends.

Behaviour:
- Reset values: `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_done`=0; FSM=IDLE; bit counter, baud counter and shift register = 0.
- Reset is honoured mid-frame: the line returns high immediately and any partial frame is discarded.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `o_tx`=1. On accept, latch `i_data` into the shift register and go to START. `o_tx` goes low on the edge after the accept edge (1-cycle latency).
  - START: `o_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: drive the current bit for `CLKS_PER_BIT` cycles, then advance the shift register.
    - After 8 bits (3-bit counter reaches 7 at the end of the period), go to STOP.
    - Shift direction is set by `MSB_FIRST`.
  - STOP: `o_tx`=1 for `STOP_BITS` × `CLKS_PER_BIT` cycles.
- Frame length: (9 + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- `o_ready` (no FIFO):
  - High in IDLE.
  - High in the final cycle of STOP. An accept in that cycle goes directly to START, giving back-to-back frames with no extra idle bit.
  - Low at all other times.
- `i_data` is sampled only on the accept edge; later changes have no effect on the current frame.
- Baud counter width is `$clog2(CLKS_PER_BIT+1)`. For `CLKS_PER_BIT`=1 it is effectively unused and every state advances every cycle.
- `o_done` fires once per frame, including when the next frame starts back-to-back.
- `i_valid` while `o_ready`=0: ignored; no data is stored.

Optional Feature:
- Macro: `UART_TX_FIFO_EN`.
- Defined:
  - A `FIFO_DEPTH`-entry FIFO sits between the handshake and the FSM; `o_ready` = !full.
  - The FSM pops whenever it is idle (or in the last STOP cycle) and the FIFO is not empty. The first start bit appears 2 cycles after the first accept.
  - Push and pop on the same edge are both honoured; the count is unchanged.
  - When full, `o_ready`=0 even if a pop happens on that edge; there is no bypass.
  - Pointer wrap-around uses an extra MSB to distinguish full from empty.
  - `o_busy` = FSM not in IDLE, or FIFO not empty.
- Undefined: single-byte holding register only; behaviour as above.

Decomposition:
- Shared package `uart_pkg`:
  - State encoding `uart_tx_state_t` {IDLE, START, DATA, STOP}.
  - `UART_DATA_BITS`=8.
  - `UART_LINE_IDLE`=1'b1.
- The receiver's state constants move into the same package.
- Sub-module `uart_tx_fifo` (synchronous, single-clock, same reset), instantiated only under `UART_TX_FIFO_EN`.

Test Plan:
- Reset, then hold `i_valid`=0 for 50 cycles → `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_done`=0 throughout.
- `CLKS_PER_BIT`=1, `MSB_FIRST`=1, send 0xA5 → `o_tx` from cycle +1 = 0,1,0,1,0,0,1,0,1,1; `o_done` pulses at cycle +11; loopback into the receiver gives `o_data`=0xA5 with `o_valid`.
- `i_valid` held high with 0x00 then 0xFF back-to-back → second start bit immediately follows the first stop bit; line = 0,00000000,1,0,11111111,1; two `o_done` pulses, 10 cycles apart.
- `CLKS_PER_BIT`=4, `STOP_BITS`=2, send 0x3C → each bit held 4 cycles; frame is 44 cycles; `o_ready` low for cycles 1–43 after accept.
- Assert `i_rst_n`=0 during data bit 3 of 0x81 → `o_tx`=1 asynchronously; after release, the next byte 0x42 is sent cleanly.
- `UART_TX_FIFO_EN`, `FIFO_DEPTH`=4, push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles → `o_ready` drops once the FIFO is full; bytes serialised in order; none lost or duplicated.
